// File: rtl/mac_accum_drain.sv
`default_nettype none
// ============================================================================
// Module      : mac_accum_drain
// Description : Run controller and requantising drain for the precision-
//               scalable MAC. It subtracts accumulator snapshots per lane,
//               then rounds, shifts, applies ReLU and saturates to int8.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_accum_drain #(
    parameter int ACC_W = 56,
    parameter int CNT_W = 16,
    parameter int OUT_W = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [CNT_W-1:0]     length,
    input  logic [1:0]           prec_level,
    input  logic [5:0]           shamt,
    input  logic                 relu_en,
    output logic                 mac_en,
    output logic [1:0]           mac_prec,
    input  logic [ACC_W-1:0]     mac_result,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*OUT_W-1:0]   out_data,
    output logic [3:0]           out_lane_mask,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRIME   = 3'd1,
        S_BASE    = 3'd2,
        S_ACCUM   = 3'd3,
        S_CAPTURE = 3'd4,
        S_REQ     = 3'd5,
        S_OUT     = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   len_q, cnt_q;
    logic [1:0]         prec_q;
    logic [5:0]         shamt_q;
    logic               relu_q;
    logic [ACC_W-1:0]   base_q;
    logic [56:0]        diff_q [4];
    logic [56:0]        diff_d [4];
    logic [4*OUT_W-1:0] data_q, req_d;

    logic               w_accept;
    logic [3:0]         w_mask;
    logic [55:0]        w_d56;
    logic [27:0]        w_d28 [2];
    logic [13:0]        w_d14 [4];

    // Round-half-up, arithmetic shift, optional ReLU, saturate to int8.
    function automatic logic [7:0] requant(input logic [56:0] v,
                                           input logic [5:0]  sh,
                                           input logic        relu);
        logic signed [57:0] t;
        logic signed [57:0] rnd;
        t   = signed'({v[56], v});
        rnd = '0;
        if (sh != 6'd0)
            rnd = 58'sd1 <<< (sh - 6'd1);
        t = (t + rnd) >>> sh;
        if (relu && (t < 58'sd0))
            t = '0;
        if (t > 58'sd127)
            requant = 8'h7F;
        else if (t < -58'sd128)
            requant = 8'h80;
        else
            requant = t[7:0];
    endfunction

    assign w_accept = (state_q == S_IDLE) && start && (prec_level != 2'b11);
    assign w_d56    = mac_result - base_q;

    // Lane-local subtraction so no borrow crosses a lane boundary.
    generate
        for (genvar g = 0; g < 2; g++) begin : g_lane28
            assign w_d28[g] = mac_result[28*g +: 28] - base_q[28*g +: 28];
        end
        for (genvar g = 0; g < 4; g++) begin : g_lane14
            assign w_d14[g] = mac_result[14*g +: 14] - base_q[14*g +: 14];
        end
    endgenerate

    always_comb begin
        case (prec_q)
            2'b00:   w_mask = 4'b0001;
            2'b01:   w_mask = 4'b0011;
            default: w_mask = 4'b1111;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 4; i++)
            diff_d[i] = '0;
        case (prec_q)
            2'b00: diff_d[0] = {w_d56[55], w_d56};
            2'b01: begin
                for (int i = 0; i < 2; i++)
                    diff_d[i] = {{29{w_d28[i][27]}}, w_d28[i]};
            end
            default: begin
                for (int i = 0; i < 4; i++)
                    diff_d[i] = {{43{w_d14[i][13]}}, w_d14[i]};
            end
        endcase
    end

    always_comb begin
        req_d = '0;
        for (int i = 0; i < 4; i++)
            if (w_mask[i])
                req_d[8*i +: 8] = requant(diff_q[i], shamt_q, relu_q);
    end

    always_comb begin
        state_d   = state_q;
        mac_en    = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_IDLE:    if (w_accept) state_d = S_PRIME;
            S_PRIME: begin
                mac_en  = 1'b1;
                state_d = S_BASE;
            end
            S_BASE:    state_d = (len_q == '0) ? S_CAPTURE : S_ACCUM;
            S_ACCUM: begin
                mac_en = 1'b1;
                if (cnt_q == (len_q - c_ONE))
                    state_d = S_CAPTURE;
            end
            S_CAPTURE: state_d = S_REQ;
            S_REQ:     state_d = S_OUT;
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_q   <= '0;
            cnt_q   <= '0;
            prec_q  <= 2'b00;
            shamt_q <= '0;
            relu_q  <= 1'b0;
            base_q  <= '0;
            data_q  <= '0;
            for (int i = 0; i < 4; i++)
                diff_q[i] <= '0;
        end else begin
            if (w_accept) begin
                len_q   <= length;
                prec_q  <= prec_level;
                shamt_q <= shamt;
                relu_q  <= relu_en;
            end
            case (state_q)
                S_BASE: begin
                    base_q <= mac_result;
                    cnt_q  <= '0;
                end
                S_ACCUM:   cnt_q  <= cnt_q + c_ONE;
                S_CAPTURE: diff_q <= diff_d;
                S_REQ:     data_q <= req_d;
                default: ;
            endcase
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign mac_prec      = prec_q;
    assign out_data      = data_q;
    assign out_lane_mask = out_valid ? w_mask : 4'b0000;

endmodule
`default_nettype wire

// File: tb/tb_mac_accum_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_accum_drain
// Description : Self-checking bench with a lane-aware MAC accumulator model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_accum_drain;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] length = '0;
    logic [1:0]  prec_level = '0;
    logic [5:0]  shamt = '0;
    logic        relu_en = 1'b0;
    logic        mac_en;
    logic [1:0]  mac_prec;
    logic [55:0] mac_result;
    logic        busy;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  out_lane_mask;
    logic        done;

    logic [55:0] acc;
    logic        seen;
    logic [55:0] prod_w = '0;
    logic [55:0] stale_w = '0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  prec;
        logic [15:0] len;
        logic [5:0]  sh;
        logic        relu;
        int          p0, p1, p2, p3;
        int          s0, s1, s2, s3;
        logic [31:0] exp_data;
        logic [3:0]  exp_mask;
    } vec_t;

    vec_t vecs [10];

    mac_accum_drain dut (
        .clk           (clk),
        .rstn          (rstn),
        .start         (start),
        .length        (length),
        .prec_level    (prec_level),
        .shamt         (shamt),
        .relu_en       (relu_en),
        .mac_en        (mac_en),
        .mac_prec      (mac_prec),
        .mac_result    (mac_result),
        .busy          (busy),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_lane_mask (out_lane_mask),
        .done          (done)
    );

    always #5 clk = ~clk;

    function automatic logic [55:0] pack(input logic [1:0] pr,
                                         input int a, input int b,
                                         input int c, input int d);
        logic [31:0] ua, ub, uc, ud;
        ua = a; ub = b; uc = c; ud = d;
        case (pr)
            2'b00:   pack = {{24{ua[31]}}, ua};
            2'b01:   pack = {ub[27:0], ua[27:0]};
            default: pack = {ud[13:0], uc[13:0], ub[13:0], ua[13:0]};
        endcase
    endfunction

    function automatic logic [55:0] ladd(input logic [55:0] x,
                                         input logic [55:0] y,
                                         input logic [1:0]  pr);
        case (pr)
            2'b00:   ladd = x + y;
            2'b01:   ladd = {x[55:28] + y[55:28], x[27:0] + y[27:0]};
            default: ladd = {x[55:42] + y[55:42], x[41:28] + y[41:28],
                             x[27:14] + y[27:14], x[13:0] + y[13:0]};
        endcase
    endfunction

    // MAC model: the first enabled edge of a run adds stale products.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc  <= '0;
            seen <= 1'b0;
        end else begin
            if (!busy)
                seen <= 1'b0;
            else if (mac_en)
                seen <= 1'b1;
            if (mac_en)
                acc <= ladd(acc, seen ? prod_w : stale_w, mac_prec);
        end
    end
    assign mac_result = acc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        prec_level = v.prec;
        length     = v.len;
        shamt      = v.sh;
        relu_en    = v.relu;
        prod_w     = pack(v.prec, v.p0, v.p1, v.p2, v.p3);
        stale_w    = pack(v.prec, v.s0, v.s1, v.s2, v.s3);
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!out_valid && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 64'(n), 64'(int'(v.len) + 4));
        chk("data", 64'(out_data), 64'(v.exp_data));
        chk("mask", 64'(out_lane_mask), 64'(v.exp_mask));
        chk("done_pre", 64'(done), 64'd0);
        out_ready = 1'b1;
        #1;
        chk("done", 64'(done), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("busy_after", 64'(busy), 64'd0);
        chk("valid_after", 64'(out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t r;
        logic [31:0] held;

        // The first vector relies on a freshly reset accumulator so lanes 0/2 wrap.
        vecs[0] = '{2'd2, 16'd1, 6'd0, 1'b0, 5, -6, 127, -200, 16380, 3, 16383, 1, 32'h807FFA05, 4'hF};
        vecs[1] = '{2'd2, 16'd2, 6'd1, 1'b1, 10, -3, 1, 60, 0, 0, 0, 0, 32'h3C01000A, 4'hF};
        vecs[2] = '{2'd0, 16'd3, 6'd0, 1'b0, 30, 0, 0, 0, 12345, 0, 0, 0, 32'h0000005A, 4'h1};
        vecs[3] = '{2'd0, 16'd3, 6'd2, 1'b0, 30, 0, 0, 0, -7, 0, 0, 0, 32'h00000017, 4'h1};
        vecs[4] = '{2'd0, 16'd4, 6'd0, 1'b0, 12700, 0, 0, 0, 99, 0, 0, 0, 32'h0000007F, 4'h1};
        vecs[5] = '{2'd1, 16'd3, 6'd3, 1'b0, 100, -100, 0, 0, 5, 6, 0, 0, 32'h0000DB26, 4'h3};
        vecs[6] = '{2'd1, 16'd3, 6'd3, 1'b1, 100, -100, 0, 0, 5, 6, 0, 0, 32'h00000026, 4'h3};
        vecs[7] = '{2'd0, 16'd3, 6'd0, 1'b0, -50, 0, 0, 0, 8, 0, 0, 0, 32'h00000080, 4'h1};
        vecs[8] = '{2'd0, 16'd1, 6'd4, 1'b0, -24, 0, 0, 0, 3, 0, 0, 0, 32'h000000FF, 4'h1};
        vecs[9] = '{2'd0, 16'd0, 6'd0, 1'b0, 30, 0, 0, 0, 500, 0, 0, 0, 32'h00000000, 4'h1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mac_en", 64'(mac_en), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_mask", 64'(out_lane_mask), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_prec", 64'(mac_prec), 64'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++)
            run_vec(vecs[i]);

        // Reserved precision must not start a run.
        prec_level = 2'b11;
        length     = 16'd2;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("prec11_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk("prec11_mac_en", 64'(mac_en), 64'd0);

        // Backpressure with stray starts, then a start coinciding with acceptance.
        prec_level = 2'b00;
        length     = 16'd2;
        shamt      = 6'd0;
        relu_en    = 1'b0;
        prod_w     = pack(2'b00, 7, 0, 0, 0);
        stale_w    = pack(2'b00, 1, 0, 0, 0);
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("bp_valid", 64'(out_valid), 64'd1);
        held = out_data;
        chk("bp_data", 64'(held), 64'h0E);
        for (int k = 0; k < 5; k++) begin
            start      = (k == 1 || k == 3);
            length     = 16'd1;
            prec_level = 2'b01;
            @(posedge clk); #1;
            chk("bp_hold_data", 64'(out_data), 64'(held));
            chk("bp_hold_done", 64'(done), 64'd0);
        end
        chk("bp_hold_mask", 64'(out_lane_mask), 64'h1);
        start     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("bp_done", 64'(done), 64'd1);
        @(posedge clk); #1;
        start     = 1'b0;
        out_ready = 1'b0;
        chk("b2b_busy", 64'(busy), 64'd0);
        chk("b2b_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        chk("b2b_still_idle", 64'(busy), 64'd0);

        // Reset asserted in the third ACCUM cycle aborts the run.
        prec_level = 2'b10;
        length     = 16'd5;
        prod_w     = pack(2'b10, 1, 2, 3, 4);
        stale_w    = '0;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_mac_en", 64'(mac_en), 64'd1);
        rstn = 1'b0;
        #1;
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_mac_en_rst", 64'(mac_en), 64'd0);
        chk("mid_valid", 64'(out_valid), 64'd0);
        chk("mid_data", 64'(out_data), 64'd0);
        chk("mid_mask", 64'(out_lane_mask), 64'd0);
        chk("mid_prec", 64'(mac_prec), 64'd0);
        chk("mid_done", 64'(done), 64'd0);
        #2;
        rstn = 1'b1;
        @(posedge clk); #1;

        r = '{2'd0, 16'd1, 6'd0, 1'b0, 42, 0, 0, 0, 9, 0, 0, 0, 32'h0000002A, 4'h1};
        run_vec(r);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
